wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter and register scoreboard for the RISC-V core. Sits between the execution unit (EXU) and load/store unit (LSU) result channels and the register-file write port (ioRD). It accepts at most one result per cycle through round-robin arbitration and drives a registered single-write port. It also keeps a per-register pending-write scoreboard that decode queries for RAW/WAW hazard stalls.

## Interface
- REG_NUM_WIDTH, 5, register index width (2^REG_NUM_WIDTH architectural registers)
- REG_WIDTH, 32, register data width

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- ioIssue_en  in  1  decode issues an instruction that writes ioIssue_rd
- ioIssue_rd  in  REG_NUM_WIDTH  destination of issued instruction
- ioExu_valid  in  1  EXU result available
- ioExu_ready  out  1  EXU result accepted this cycle when valid&&ready
- ioExu_rd  in  REG_NUM_WIDTH  EXU destination
- ioExu_data  in  REG_WIDTH  EXU result
- ioLsu_valid / ioLsu_ready / ioLsu_rd / ioLsu_data: same as EXU, for the LSU channel
- ioRD_en  out  1  register-file write enable (registered)
- ioRD_addr  out  REG_NUM_WIDTH  write address (registered)
- ioRD_data  out  REG_WIDTH  write data (registered)
- ioQuery_rs1, ioQuery_rs2  in  REG_NUM_WIDTH  decode source indices
- ioQuery_rs1_busy, ioQuery_rs2_busy  out  1  scoreboard bit of queried register (combinational)
- ioWbErr  out  1  sticky: a writeback targeted a non-pending, non-zero register

## Operation
- State:
  - scoreboard vector `pend[2^REG_NUM_WIDTH-1:0]`
  - round-robin pointer `last` (0=EXU, 1=LSU)
  - write-port registers
  - ioWbErr flag
- Arbitration (combinational):
  - ioExu_ready = !ioLsu_valid || last==LSU
  - ioLsu_ready = !ioExu_valid || last==EXU
  - The two readys are never simultaneously accepted: when both channels are valid, exactly one grant is issued.
  - On an accept, `last` becomes the granted channel. `last` holds when nothing is accepted.
- Write port: on the accept edge, register the granted channel's rd/data.
  - ioRD_en = 1 the next cycle iff rd != 0.
  - With no accept, ioRD_en = 0 the next cycle. ioRD_addr/ioRD_data hold their last values.
- Scoreboard:
  - On an accept with rd != 0, clear `pend[rd]`.
  - On ioIssue_en with ioIssue_rd != 0, set `pend[ioIssue_rd]`.
  - When set and clear hit the same index in the same cycle, set wins (new WAW producer).
  - `pend[0]` is constant 0.
- Query: ioQuery_rsN_busy = `pend[ioQuery_rsN]` from the register only. A same-cycle set or clear is not visible until the next cycle. Index 0 always returns 0.
- Error: an accept with rd != 0 and `pend[rd]`==0 sets ioWbErr. It stays set until reset. The write still proceeds.
- Writes to x0 are accepted (ready behaves normally) but produce no ioRD_en and no scoreboard change.

## Timing
- Reset values:
  - ioRD_en=0, ioRD_addr=0, ioRD_data=0
  - `pend`=all zero, `last`=LSU (first tie grants EXU)
  - ioWbErr=0
- Readys and busy flags during reset are combinational from the reset state values.
- Latency: accept at edge N -> ioRD_en high in cycle N+1 -> register file updated at edge N+1.
- Throughput: one writeback per cycle sustained. With both channels continuously valid, grants alternate EXU, LSU, EXU, ...
- Valid/ready rules:
  - Producers hold valid, rd and data stable until accepted.
  - ready may depend on the other channel's valid, but never on its own channel's valid.
- Reset asserted mid-operation clears the in-flight write immediately (asynchronous), so ioRD_en drops without waiting for a clock edge. Pending bits are lost; decode re-issues after reset.
- An issue and a writeback to the same rd in the same cycle leaves `pend[rd]`=1, and the busy flag reads 1 from the next cycle.

## Test plan
- Reset, then issue rd=5 -> next cycle ioQuery_rs1=5 gives busy=1. EXU valid rd=5 data=0xDEADBEEF accepted -> next cycle ioRD_en=1, addr=5, data=0xDEADBEEF, busy=0, ioWbErr=0.
- Issue rd=3 and rd=4, then both channels valid every cycle (EXU rd=3, LSU rd=4) -> EXU accepted first. LSU is accepted on the following cycle. ioRD_en is high for two consecutive cycles with addr 3 then 4.
- Issue rd=7 in the same cycle that LSU writes back rd=7 (previously pending) -> ioRD_en=1 for addr 7, and busy for 7 remains 1.
- EXU writeback to rd=0 with data 0x1234 -> ioExu_ready=1, ioRD_en stays 0, ioWbErr stays 0. Query rs2=0 -> busy=0.
- LSU writeback to non-pending rd=9 -> write performed, ioWbErr=1 and held until reset.
- Assert reset asynchronously in the cycle after an accept -> ioRD_en=0 immediately, all busy flags 0, ioWbErr=0. The next tie is granted to EXU.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin EXU/LSU writeback arbiter with pending-write scoreboard
module wb_arbiter #(
    parameter int REG_NUM_WIDTH = 5,
    parameter int REG_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ioIssue_en,
    input  logic [REG_NUM_WIDTH-1:0] ioIssue_rd,
    input  logic                     ioExu_valid,
    output logic                     ioExu_ready,
    input  logic [REG_NUM_WIDTH-1:0] ioExu_rd,
    input  logic [REG_WIDTH-1:0]     ioExu_data,
    input  logic                     ioLsu_valid,
    output logic                     ioLsu_ready,
    input  logic [REG_NUM_WIDTH-1:0] ioLsu_rd,
    input  logic [REG_WIDTH-1:0]     ioLsu_data,
    output logic                     ioRD_en,
    output logic [REG_NUM_WIDTH-1:0] ioRD_addr,
    output logic [REG_WIDTH-1:0]     ioRD_data,
    input  logic [REG_NUM_WIDTH-1:0] ioQuery_rs1,
    input  logic [REG_NUM_WIDTH-1:0] ioQuery_rs2,
    output logic                     ioQuery_rs1_busy,
    output logic                     ioQuery_rs2_busy,
    output logic                     ioWbErr
);
    localparam int NREG = 1 << REG_NUM_WIDTH;

    typedef enum logic {
        CH_EXU = 1'b0,
        CH_LSU = 1'b1
    } chan_t;

    logic [NREG-1:0]          r_pend;
    chan_t                    r_last;
    logic                     r_rd_en;
    logic [REG_NUM_WIDTH-1:0] r_rd_addr;
    logic [REG_WIDTH-1:0]     r_rd_data;
    logic                     r_err;

    logic                     w_exu_ready;
    logic                     w_lsu_ready;
    logic                     w_exu_acc;
    logic                     w_lsu_acc;
    logic                     w_acc;
    chan_t                    w_grant;
    logic [REG_NUM_WIDTH-1:0] w_rd;
    logic [REG_WIDTH-1:0]     w_data;
    logic                     w_rd_nz;
    logic                     w_err_set;
    logic [NREG-1:0]          w_pend_nxt;

    // A channel's ready never looks at its own valid, so on a tie exactly one side is granted.
    assign w_exu_ready = !ioLsu_valid || (r_last == CH_LSU);
    assign w_lsu_ready = !ioExu_valid || (r_last == CH_EXU);
    assign w_exu_acc   = ioExu_valid && w_exu_ready;
    assign w_lsu_acc   = ioLsu_valid && w_lsu_ready;
    assign w_acc       = w_exu_acc || w_lsu_acc;
    assign w_grant     = w_lsu_acc ? CH_LSU : CH_EXU;
    assign w_rd        = w_lsu_acc ? ioLsu_rd : ioExu_rd;
    assign w_data      = w_lsu_acc ? ioLsu_data : ioExu_data;
    assign w_rd_nz     = (w_rd != '0);
    assign w_err_set   = w_acc && w_rd_nz && !r_pend[w_rd];

    // Clear on writeback first, then set on issue so a same-cycle new producer wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_acc && w_rd_nz) begin
            w_pend_nxt[w_rd] = 1'b0;
        end
        if (ioIssue_en && (ioIssue_rd != '0)) begin
            w_pend_nxt[ioIssue_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend    <= '0;
            r_last    <= CH_LSU;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_rd_en <= w_acc && w_rd_nz;
            if (w_acc) begin
                r_last    <= w_grant;
                r_rd_addr <= w_rd;
                r_rd_data <= w_data;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ioExu_ready      = w_exu_ready;
    assign ioLsu_ready      = w_lsu_ready;
    assign ioRD_en          = r_rd_en;
    assign ioRD_addr        = r_rd_addr;
    assign ioRD_data        = r_rd_data;
    assign ioQuery_rs1_busy = r_pend[ioQuery_rs1];
    assign ioQuery_rs2_busy = r_pend[ioQuery_rs2];
    assign ioWbErr          = r_err;
endmodule
